// File: rtl/scr_lock_ctrl.sv
// Scrambler lock controller: acquires 33 received bits to seed the slave
// x^33+x^20+1 LFSR, verifies CHK_LEN consecutive predictions, then monitors
// the bit-error density per WIN-bit window and drops lock at ERR_MAX errors.
module scr_lock_ctrl #(
  parameter int CHK_LEN = 64,
  parameter int WIN     = 256,
  parameter int ERR_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        rx_valid,
  input  logic        rx_bit,
  input  logic [32:0] scr_rand,
  output logic        scr_load,
  output logic        scr_valid,
  output logic [32:0] scr_seed,
  output logic        locked,
  output logic        lock_lost,
  output logic        bit_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACQ   = 3'd1;
  localparam logic [2:0] SEED  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] LOCK  = 3'd4;

  localparam int MW = $clog2(CHK_LEN + 1);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(ERR_MAX + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(CHK_LEN - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN - 1);
  localparam logic [EW-1:0] ERR_LIM    = EW'(ERR_MAX);

  logic [2:0]    state, state_nx;
  logic [32:0]   cap, cap_nx;
  logic [5:0]    cap_cnt, cap_cnt_nx;
  logic [MW-1:0] match_cnt, match_cnt_nx;
  logic [WW-1:0] win_cnt, win_cnt_nx;
  logic [EW-1:0] err_cnt, err_cnt_nx;
  logic [EW-1:0] err_inc;
  logic          bit_err_nx, lock_lost_nx;
  logic          pred, mism;

  assign pred    = scr_rand[32] ^ scr_rand[19];
  assign mism    = rx_valid && (rx_bit != pred);
  assign err_inc = (err_cnt == ERR_LIM) ? err_cnt : err_cnt + EW'(1);

  // Scrambler control: hold LFSR cleared while acquiring, load the captured
  // seed for one cycle, then step it only on valid bits (reload own state otherwise).
  always_comb begin
    scr_load  = 1'b1;
    scr_valid = 1'b0;
    scr_seed  = '0;
    case (state)
      SEED: begin
        scr_load = 1'b0;
        scr_seed = rx_valid ? {cap[31:0], rx_bit} : cap;
      end
      CHECK, LOCK: begin
        scr_load  = 1'b0;
        scr_valid = rx_valid;
        scr_seed  = scr_rand;
      end
      default: ;
    endcase
  end

  // Next-state and counter update; en low overrides every other transition.
  always_comb begin
    state_nx     = state;
    cap_nx       = cap;
    cap_cnt_nx   = cap_cnt;
    match_cnt_nx = match_cnt;
    win_cnt_nx   = win_cnt;
    err_cnt_nx   = err_cnt;
    bit_err_nx   = 1'b0;
    lock_lost_nx = 1'b0;
    if (!en) begin
      state_nx     = IDLE;
      cap_cnt_nx   = '0;
      match_cnt_nx = '0;
      win_cnt_nx   = '0;
      err_cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx   = ACQ;
          cap_cnt_nx = '0;
        end
        ACQ: begin
          if (rx_valid) begin
            cap_nx = {cap[31:0], rx_bit};
            if (cap_cnt == 6'd32) begin
              state_nx   = SEED;
              cap_cnt_nx = '0;
            end else begin
              cap_cnt_nx = cap_cnt + 6'd1;
            end
          end
        end
        SEED: begin
          state_nx     = CHECK;
          match_cnt_nx = '0;
        end
        CHECK: begin
          if (rx_valid) begin
            if (mism) begin
              bit_err_nx   = 1'b1;
              state_nx     = ACQ;
              cap_cnt_nx   = '0;
              match_cnt_nx = '0;
            end else if (match_cnt == MATCH_LAST) begin
              state_nx     = LOCK;
              match_cnt_nx = '0;
              win_cnt_nx   = '0;
              err_cnt_nx   = '0;
            end else begin
              match_cnt_nx = match_cnt + MW'(1);
            end
          end
        end
        LOCK: begin
          if (rx_valid) begin
            bit_err_nx = mism;
            // Threshold is tested before the window wrap so an error on the
            // last bit of a window still counts against that window.
            if (mism && (err_inc == ERR_LIM)) begin
              state_nx     = ACQ;
              lock_lost_nx = 1'b1;
              cap_cnt_nx   = '0;
              match_cnt_nx = '0;
              win_cnt_nx   = '0;
              err_cnt_nx   = '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt_nx = '0;
              err_cnt_nx = '0;
            end else begin
              win_cnt_nx = win_cnt + WW'(1);
              err_cnt_nx = mism ? err_inc : err_cnt;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, capture, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap       <= '0;
      cap_cnt   <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      err_cnt   <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      bit_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cap       <= cap_nx;
      cap_cnt   <= cap_cnt_nx;
      match_cnt <= match_cnt_nx;
      win_cnt   <= win_cnt_nx;
      err_cnt   <= err_cnt_nx;
      locked    <= (state_nx == LOCK);
      lock_lost <= lock_lost_nx;
      bit_err   <= bit_err_nx;
    end
  end

endmodule

// File: tb/tb_scr_lock_ctrl.sv
// Bench for scr_lock_ctrl: a slave scrambler LFSR driven by the DUT, a
// transmit LFSR producing the received stream, and a sequence-level model of
// the lock procedure compared against the DUT outputs every cycle.
module tb_scr_lock_ctrl;

  localparam int CHK_LEN = 64;
  localparam int WIN     = 256;
  localparam int ERR_MAX = 8;

  localparam int M_IDLE = 0, M_ACQ = 1, M_SEED = 2, M_CHECK = 3, M_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic [32:0] scr_rand;
  logic        scr_load, scr_valid, locked, lock_lost, bit_err;
  logic [32:0] scr_seed;

  int n_tests = 0;
  int n_fail  = 0;
  int n_be    = 0;
  int n_ll    = 0;
  int vcount  = 0;
  logic [32:0] tx = 33'h1_2345_6789;

  // model state
  int   m_mode = M_IDLE;
  int   m_ncap = 0, m_match = 0, m_wpos = 0, m_errs = 0;
  logic m_bit_err = 1'b0, m_lost = 1'b0;
  logic m_cap[$];
  logic m_seq[$];

  scr_lock_ctrl #(.CHK_LEN(CHK_LEN), .WIN(WIN), .ERR_MAX(ERR_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .scr_rand(scr_rand), .scr_load(scr_load), .scr_valid(scr_valid),
    .scr_seed(scr_seed), .locked(locked), .lock_lost(lock_lost), .bit_err(bit_err)
  );

  always #5 clk = ~clk;

  // Slave scrambler: clear, step, or load seed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          scr_rand <= '0;
    else if (scr_load)   scr_rand <= '0;
    else if (scr_valid)  scr_rand <= {scr_rand[31:0], scr_rand[32] ^ scr_rand[19]};
    else                 scr_rand <= scr_seed;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ncap = 0; m_match = 0; m_wpos = 0; m_errs = 0;
    m_bit_err = 1'b0; m_lost = 1'b0;
    m_cap.delete(); m_seq.delete();
  endtask

  // Reference sequence after seeding obeys b[n] = b[n-33] ^ b[n-20];
  // m_seq holds the last 33 reference bits, oldest first.
  task automatic model_step(input logic e, input logic v, input logic b);
    logic p;
    m_bit_err = 1'b0;
    m_lost    = 1'b0;
    if (!e) begin
      m_mode = M_IDLE; m_ncap = 0; m_match = 0; m_wpos = 0; m_errs = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_ACQ; m_ncap = 0; end
        M_ACQ: if (v) begin
          m_cap.push_back(b);
          if (m_cap.size() > 33) m_cap.delete(0);
          m_ncap++;
          if (m_ncap == 33) begin m_mode = M_SEED; m_ncap = 0; end
        end
        M_SEED: begin
          m_seq = m_cap;
          if (v) begin m_seq.push_back(b); m_seq.delete(0); end
          m_match = 0;
          m_mode = M_CHECK;
        end
        M_CHECK: if (v) begin
          p = m_seq[0] ^ m_seq[13];
          m_seq.delete(0); m_seq.push_back(p);
          if (b !== p) begin
            m_bit_err = 1'b1; m_mode = M_ACQ; m_ncap = 0; m_match = 0;
          end else begin
            m_match++;
            if (m_match == CHK_LEN) begin m_mode = M_LOCK; m_wpos = 0; m_errs = 0; end
          end
        end
        M_LOCK: if (v) begin
          p = m_seq[0] ^ m_seq[13];
          m_seq.delete(0); m_seq.push_back(p);
          if (b !== p) begin m_bit_err = 1'b1; m_errs++; end
          if (m_errs >= ERR_MAX) begin
            m_lost = 1'b1; m_mode = M_ACQ; m_ncap = 0; m_match = 0; m_wpos = 0; m_errs = 0;
          end else begin
            m_wpos++;
            if (m_wpos == WIN) begin m_wpos = 0; m_errs = 0; end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Per-cycle comparison of every registered and control output.
  always @(posedge clk) begin
    if (rst_n) model_step(en, rx_valid, rx_bit);
    #1;
    chk("locked", locked, m_mode == M_LOCK);
    chk("lock_lost", lock_lost, m_lost);
    chk("bit_err", bit_err, m_bit_err);
    chk("scr_load", scr_load, (m_mode == M_IDLE) || (m_mode == M_ACQ));
    chk("scr_valid", scr_valid, ((m_mode == M_CHECK) || (m_mode == M_LOCK)) && rx_valid);
    if (bit_err === 1'b1) n_be++;
    if (lock_lost === 1'b1) n_ll++;
  end

  task automatic cyc(input logic e, input logic v, input logic flip);
    logic b;
    @(negedge clk);
    en = e;
    rx_valid = v;
    if (v) begin
      b = tx[32] ^ tx[19];
      tx = {tx[31:0], b};
      rx_bit = b ^ flip;
      vcount++;
    end else begin
      rx_bit = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #2;
  endtask

  // mode 0: continuous valid; 1: strict 1-0 toggle; 2: toggle but valid in SEED
  task automatic run_lock(input bit restart, input int mode, output int nb);
    logic ph, forced, v;
    if (restart) begin cyc(1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); end
    vcount = 0; ph = 1'b1; forced = 1'b0; nb = -1;
    for (int k = 0; k < 400; k++) begin
      v = (mode == 0) ? 1'b1 : ph;
      if (mode == 2 && vcount == 33 && !forced) begin v = 1'b1; forced = 1'b1; end
      ph = ~ph;
      cyc(1'b1, v, 1'b0);
      if (locked === 1'b1) begin nb = vcount; break; end
    end
  endtask

  initial begin
    int nb, be0, ll0;
    // reset values
    #12;
    chk("rst_locked", locked, 1'b0);
    chk("rst_lock_lost", lock_lost, 1'b0);
    chk("rst_bit_err", bit_err, 1'b0);
    chk("rst_scr_load", scr_load, 1'b1);
    chk("rst_scr_valid", scr_valid, 1'b0);
    chk("rst_scr_seed", scr_seed, 33'h0);
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // clean acquisition: 33 capture + 1 seed + 64 check bits
    be0 = n_be;
    run_lock(1'b1, 0, nb);
    chk("lock_bits_cont", nb, 98);
    chk("no_biterr_clean", n_be - be0, 0);

    // mismatch at the 10th CHECK match
    cyc(1'b0, 1'b0, 1'b0);
    chk("en_drop_locked", locked, 1'b0);
    chk("en_drop_load", scr_load, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    vcount = 0;
    for (int i = 1; i <= 43; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("chk_flip_biterr", bit_err, 1'b1);
    chk("chk_flip_acq", scr_load, 1'b1);
    be0 = n_be;
    run_lock(1'b0, 0, nb);
    chk("relock_bits", nb, 98);
    chk("relock_no_err", n_be - be0, 0);

    // 7 errors tolerated, 8th in same window loses lock
    be0 = n_be; ll0 = n_ll;
    for (int i = 1; i <= 150; i++) begin
      cyc(1'b1, 1'b1, (i % 20) == 10);
      if (i == 149) begin
        chk("err7_locked", locked, 1'b1);
        chk("err7_pulses", n_be - be0, 7);
        chk("err7_no_loss", n_ll - ll0, 0);
      end
    end
    chk("err8_lost", lock_lost, 1'b1);
    chk("err8_unlocked", locked, 1'b0);
    chk("err8_acq", scr_load, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("lost_one_cycle", lock_lost, 1'b0);

    // 4 errors each side of a window boundary
    run_lock(1'b1, 0, nb);
    chk("lock_w", nb, 98);
    be0 = n_be; ll0 = n_ll;
    for (int i = 1; i <= 300; i++) cyc(1'b1, 1'b1, (i >= 253) && (i <= 260));
    chk("split_locked", locked, 1'b1);
    chk("split_no_loss", n_ll - ll0, 0);
    chk("split_pulses", n_be - be0, 8);

    // 8th error on the last bit of a window still counts
    run_lock(1'b1, 0, nb);
    for (int i = 1; i <= 256; i++) begin
      cyc(1'b1, 1'b1, i >= 249);
      if (i == 255) chk("edge7_locked", locked, 1'b1);
    end
    chk("edge8_lost", lock_lost, 1'b1);
    chk("edge8_unlocked", locked, 1'b0);

    // toggled valid
    run_lock(1'b1, 2, nb);
    chk("lock_bits_toggle_seedvalid", nb, 98);
    run_lock(1'b1, 1, nb);
    chk("lock_bits_toggle_strict", nb, 97);

    // random valid, rare bit errors and enable drops
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0);

    // asynchronous reset mid-CHECK
    run_lock(1'b1, 0, nb);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 1'b0);
    chk("arst_load", scr_load, 1'b1);
    chk("arst_valid", scr_valid, 1'b0);
    chk("arst_seed", scr_seed, 33'h0);
    #1;
    rst_n = 1'b1;
    run_lock(1'b0, 0, nb);
    chk("post_rst_lock", nb, 98);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scr_lock_ctrl.md
SCR_LOCK_CTRL -- requirements
Module: scr_lock_ctrl

Interface
REQ-001 Parameter CHK_LEN, default 64: consecutive matching bits required in CHECK before lock.
REQ-002 Parameter WIN, default 256: valid-bit length of the error-monitor window in LOCK.
REQ-003 Parameter ERR_MAX, default 8: mismatches within one window that force loss of lock.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  enable; low forces IDLE synchronously.
REQ-007 rx_valid  input  1  rx_bit qualifier, one received scrambled bit per asserted cycle.
REQ-008 rx_bit  input  1  received scrambler-stream bit.
REQ-009 scr_rand  input  33  current state of the slave x^33+x^20+1 scrambler LFSR.
REQ-010 scr_load  output  1  to scrambler: clear LFSR to zero.
REQ-011 scr_valid  output  1  to scrambler: advance LFSR one step.
REQ-012 scr_seed  output  33  to scrambler: value loaded when scr_load=0 and scr_valid=0.
REQ-013 locked  output  1  high while in LOCK.
REQ-014 lock_lost  output  1  one-cycle pulse on LOCK->ACQ transition.
REQ-015 bit_err  output  1  one-cycle pulse, registered, on each mismatch in CHECK or LOCK.

Function
REQ-016 FSM states IDLE, ACQ, SEED, CHECK, LOCK; en=0 moves any state to IDLE next cycle, overriding all other transitions.
REQ-017 IDLE: scr_load=1, scr_valid=0; capture count cleared; en=1 -> ACQ.
REQ-018 ACQ: scr_load=1; on each rx_valid, cap <= {cap[31:0], rx_bit} and capture count increments; 33rd captured bit -> SEED.
REQ-019 SEED (one cycle): scr_load=0, scr_valid=0, scr_seed = rx_valid ? {cap[31:0], rx_bit} : cap; -> CHECK unconditionally.
REQ-020 Predicted bit pred = scr_rand[32] ^ scr_rand[19], combinational.
REQ-021 CHECK/LOCK: scr_load=0, scr_valid=rx_valid, scr_seed=scr_rand, so LFSR holds on rx_valid=0 cycles.
REQ-022 CHECK: on rx_valid, mismatch (rx_bit != pred) -> ACQ with capture count and match count cleared; match increments match count; CHK_LEN-th consecutive match -> LOCK.
REQ-023 LOCK: on rx_valid, window count increments; mismatch increments window error count (saturating at ERR_MAX).
REQ-024 Error count reaching ERR_MAX -> ACQ next cycle; lock_lost=1 for that one cycle; all counts cleared.
REQ-025 Window count wraps WIN-1 -> 0 clearing error count; mismatch on the WIN-th bit is counted in the closing window before the clear (threshold test first).
REQ-026 Entry to LOCK clears window and error counts.
REQ-027 rx_valid=0 cycles change no counter, no cap bit and no state except SEED->CHECK and en-driven IDLE.
REQ-028 bit_err asserts the cycle after a mismatched valid bit in CHECK or LOCK, never in other states.
REQ-029 locked is registered and equals (state==LOCK).

Reset
REQ-030 rst_n low: state=IDLE, cap=0, all counts=0, locked=0, lock_lost=0, bit_err=0; scr_load=1, scr_valid=0, scr_seed=0.
REQ-031 Reset mid-operation aborts any state within the same edge-free asynchronous assertion; release resumes in IDLE.

Verification
REQ-032 Bench reference LFSR seeded 33'h1_2345_6789, en=1, continuous rx_valid -> SEED after 33 bits, locked=1 after 33+1+64 valid bits, bit_err never.
REQ-033 Same stream, one bit flipped at CHECK match 10 -> bit_err pulse, return to ACQ, lock after a further 33+1+64 clean bits.
REQ-034 Locked, 7 flips in one 256-bit window -> locked stays 1, 7 bit_err pulses; 8th flip in same window -> lock_lost pulse, state ACQ.
REQ-035 Locked, 4 flips at end of window N and 4 at start of N+1 -> no loss of lock.
REQ-036 rx_valid toggled 1-0 every cycle throughout, incl. rx_valid=1 during SEED -> lock identical to REQ-032 in valid-bit count.
REQ-037 en dropped while locked, and rst_n pulsed mid-CHECK -> IDLE, locked=0, scr_load=1 next cycle / immediately.
